// File: rtl/serial_subtractor_8_bit.sv
// Bit-serial two's-complement subtractor: diff = A - B - borrow_in, one bit per clock, LSB first.
// A start/busy/done handshake wraps a single full-subtractor cell and a borrow flop.
module serial_subtractor_8_bit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, a_sr_nxt;
    logic [WIDTH-1:0] b_sr, b_sr_nxt;
    logic [WIDTH-1:0] res_sr, res_sr_nxt;
    logic             brw, brw_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             a_msb, a_msb_nxt;
    logic             b_msb, b_msb_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic             borrow_out_nxt;
    logic             overflow_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // Full-subtractor cell on the current LSBs
    logic             d_bit_c;
    logic             brw_calc_c;
    logic [WIDTH-1:0] res_shift_c;
    logic             last_bit_c;

    always_comb begin
        d_bit_c     = a_sr[0] ^ b_sr[0] ^ brw;
        brw_calc_c  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        res_shift_c = {d_bit_c, res_sr[MSB:1]};
        last_bit_c  = (cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt      = state;
        a_sr_nxt       = a_sr;
        b_sr_nxt       = b_sr;
        res_sr_nxt     = res_sr;
        brw_nxt        = brw;
        cnt_nxt        = cnt;
        a_msb_nxt      = a_msb;
        b_msb_nxt      = b_msb;
        diff_nxt       = diff;
        borrow_out_nxt = borrow_out;
        overflow_nxt   = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = BUSY;
                    a_sr_nxt   = A;
                    b_sr_nxt   = B;
                    brw_nxt    = borrow_in;
                    a_msb_nxt  = A[MSB];
                    b_msb_nxt  = B[MSB];
                    res_sr_nxt = '0;
                    cnt_nxt    = '0;
                end
            end
            BUSY: begin
                a_sr_nxt   = {1'b0, a_sr[MSB:1]};
                b_sr_nxt   = {1'b0, b_sr[MSB:1]};
                res_sr_nxt = res_shift_c;
                brw_nxt    = brw_calc_c;
                if (last_bit_c) begin
                    // Counter is cleared rather than advanced so it never passes WIDTH-1
                    cnt_nxt        = '0;
                    state_nxt      = DONE;
                    diff_nxt       = res_shift_c;
                    borrow_out_nxt = brw_calc_c;
                    overflow_nxt   = (a_msb != b_msb) && (res_shift_c[MSB] != a_msb);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == BUSY);
        done_nxt = (state_nxt == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_sr       <= a_sr_nxt;
            b_sr       <= b_sr_nxt;
            res_sr     <= res_sr_nxt;
            brw        <= brw_nxt;
            cnt        <= cnt_nxt;
            a_msb      <= a_msb_nxt;
            b_msb      <= b_msb_nxt;
            diff       <= diff_nxt;
            borrow_out <= borrow_out_nxt;
            overflow   <= overflow_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor_8_bit.sv
// Directed bench for serial_subtractor_8_bit with hand-computed expected results.
module tb_serial_subtractor_8_bit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    serial_subtractor_8_bit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat counts edges after the sampling edge at which done is first seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        A = a; B = b; borrow_in = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, diff, borrow_out, overflow} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(8'd30, 8'd10, 1'b0, lat, bc);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d edges, want 8", lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
        total++;
        if (diff !== 8'd20) begin bad++; $display("FAIL basic_diff: got %0d, want 20", diff); end
        total++;
        if (borrow_out !== 1'b0) begin bad++; $display("FAIL basic_borrow: got %b, want 0", borrow_out); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b, want 0", overflow); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_underflow();
        int lat, bc;
        run_op(8'd10, 8'd30, 1'b0, lat, bc);
        total++;
        if (diff !== 8'd236) begin bad++; $display("FAIL under_diff: got %0d, want 236", diff); end
        total++;
        if (borrow_out !== 1'b1) begin bad++; $display("FAIL under_borrow: got %b, want 1", borrow_out); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL under_overflow: got %b, want 0", overflow); end
    endtask

    task automatic test_borrow_in();
        int lat, bc;
        run_op(8'd0, 8'd0, 1'b1, lat, bc);
        total++;
        if (diff !== 8'hFF) begin bad++; $display("FAIL bin_diff: got %h, want ff", diff); end
        total++;
        if (borrow_out !== 1'b1) begin bad++; $display("FAIL bin_borrow: got %b, want 1", borrow_out); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL bin_overflow: got %b, want 0", overflow); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(8'h80, 8'h01, 1'b0, lat, bc);
        total++;
        if (diff !== 8'h7F) begin bad++; $display("FAIL ovf_diff: got %h, want 7f", diff); end
        total++;
        if (borrow_out !== 1'b0) begin bad++; $display("FAIL ovf_borrow: got %b, want 0", borrow_out); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_overflow: got %b, want 1", overflow); end
    endtask

    // Operands change and start stays high during BUSY; result must follow the captured values
    task automatic test_protocol();
        int dones = 0;
        @(negedge clk);
        A = 8'd50; B = 8'd7; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 8'd99; B = 8'd99; borrow_in = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL proto_done_count: got %0d, want 1", dones); end
        total++;
        if (diff !== 8'd43) begin bad++; $display("FAIL proto_diff: got %0d, want 43", diff); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL proto_idle_busy: got %b, want 0", busy); end
        repeat (6) @(negedge clk);
        total++;
        if (diff !== 8'd43 || borrow_out !== 1'b0) begin
            bad++; $display("FAIL proto_hold: got diff=%0d bo=%b, want 43 0", diff, borrow_out);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        int dones = 0;
        // Leave a known nonzero diff/borrow so the reset clear is observable
        run_op(8'd0, 8'd1, 1'b0, lat, bc);
        @(negedge clk);
        A = 8'd20; B = 8'd5; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got %b, want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({busy, done, diff, borrow_out, overflow} !== 12'h000) begin
            bad++;
            $display("FAIL rst_mid_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy, done, diff, borrow_out, overflow);
        end
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d active cycles, want 0", dones); end
        run_op(8'd15, 8'd15, 1'b0, lat, bc);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL rst_after_latency: got %0d, want 8", lat); end
        total++;
        if (diff !== 8'd0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rst_after_result: got diff=%0d bo=%b ov=%b, want 0 0 0",
                            diff, borrow_out, overflow);
        end
    endtask

    // Back-to-back operations at full throughput (start re-asserted in the cycle after done)
    task automatic test_back_to_back();
        int lat, bc;
        run_op(8'hFF, 8'h00, 1'b0, lat, bc);
        total++;
        if (diff !== 8'hFF || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL b2b_first: got diff=%h bo=%b ov=%b, want ff 0 0", diff, borrow_out, overflow);
        end
        run_op(8'h7F, 8'hFF, 1'b1, lat, bc);
        total++;
        if (diff !== 8'h7F || borrow_out !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL b2b_second: got diff=%h bo=%b ov=%b, want 7f 1 0", diff, borrow_out, overflow);
        end
        run_op(8'h7F, 8'h80, 1'b0, lat, bc);
        total++;
        if (diff !== 8'hFF || borrow_out !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL b2b_third: got diff=%h bo=%b ov=%b, want ff 1 1", diff, borrow_out, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_in();
        test_overflow();
        test_protocol();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
